// File: rtl/button_event_queue_if.sv
// Key-code stream from the button event queue to the calculator core.
// FIFO head, occupancy and lost-press flag share one bundle.
interface button_event_queue_if #(
   parameter int CODE_W = 3,
   parameter int CNT_W  = 3
);
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output key_code,
      output key_valid,
      output count,
      output overflow,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  count,
      input  overflow,
      output key_ready
   );
endinterface

// File: rtl/button_event_queue.sv
// Serialises simultaneous button presses lowest-index-first into a
// first-word-fall-through FIFO of key codes; lost presses pulse overflow.
module button_event_queue #(
   parameter int NUM_BTN = 8,
   parameter int CODE_W  = 3,
   parameter int DEPTH   = 4
) (
   input  logic                       clk5,
   input  logic                       reset,
   input  logic [NUM_BTN-1:0]         press,
   button_event_queue_if.master       q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [NUM_BTN-1:0] pend;
   logic [NUM_BTN-1:0] sel;
   logic [NUM_BTN-1:0] taken;
   logic [CODE_W-1:0]  low_idx;
   logic [CODE_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [CNT_W-1:0]   count;
   logic               overflow;
   logic               push;
   logic               pop;

   // Descending scan so the lowest set bit is the last one kept.
   always_comb begin
      sel     = '0;
      low_idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel     = '0;
            sel[i]  = 1'b1;
            low_idx = CODE_W'(i);
         end
      end
   end

   assign pop   = (count != '0) & q.key_ready;
   assign push  = (pend != '0) & ((count != FULL) | pop);
   assign taken = push ? sel : '0;

   always_ff @(posedge clk5 or negedge reset) begin
      if (!reset) begin
         pend     <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         pend     <= (pend & ~taken) | press;
         overflow <= |(press & pend & ~taken);
         if (push) begin
            mem[wptr] <= low_idx;
            wptr      <= wptr + PTR_W'(1);
         end
         if (pop) rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign q.key_code  = mem[rptr];
   assign q.key_valid = (count != '0);
   assign q.count     = count;
   assign q.overflow  = overflow;
endmodule

// File: tb/tb_button_event_queue.sv
// Directed vector bench for button_event_queue (8 buttons, depth 4):
// a table of per-edge inputs and expected outputs plus an async-reset sequence.
module tb_button_event_queue;
   typedef struct {
      logic [7:0] press;
      logic       ready;
      logic       valid;
      logic [2:0] code;
      logic [2:0] count;
      logic       ovf;
   } vec_t;

   logic       clk5;
   logic       reset;
   logic [7:0] press;
   int         checks;
   int         errors;
   vec_t       vecs[$];

   button_event_queue_if #(.CODE_W(3), .CNT_W(3)) bus ();

   button_event_queue #(
      .NUM_BTN(8),
      .CODE_W (3),
      .DEPTH  (4)
   ) dut (
      .clk5 (clk5),
      .reset(reset),
      .press(press),
      .q    (bus)
   );

   initial clk5 = 1'b0;
   always #5 clk5 = ~clk5;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] p, input logic r, input logic v,
                      input logic [2:0] c, input logic [2:0] n,
                      input logic o);
      vec_t t;
      t.press = p; t.ready = r; t.valid = v;
      t.code = c; t.count = n; t.ovf = o;
      vecs.push_back(t);
   endtask

   task automatic tick();
      @(posedge clk5);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      press = '0;
      bus.key_ready = 1'b0;

      // single press
      add(8'h04, 0, 0, 0, 0, 0);
      add(8'h00, 0, 1, 2, 1, 0);
      add(8'h00, 1, 0, 0, 0, 0);
      // simultaneous presses 0,5,7
      add(8'hA1, 0, 0, 0, 0, 0);
      add(8'h00, 0, 1, 0, 1, 0);
      add(8'h00, 0, 1, 0, 2, 0);
      add(8'h00, 0, 1, 0, 3, 0);
      add(8'h00, 0, 1, 0, 3, 0);
      add(8'h00, 1, 1, 5, 2, 0);
      add(8'h00, 1, 1, 7, 1, 0);
      add(8'h00, 1, 0, 0, 0, 0);
      // buttons 0..5 into a depth-4 FIFO
      add(8'h01, 0, 0, 0, 0, 0);
      add(8'h02, 0, 1, 0, 1, 0);
      add(8'h04, 0, 1, 0, 2, 0);
      add(8'h08, 0, 1, 0, 3, 0);
      add(8'h10, 0, 1, 0, 4, 0);
      add(8'h20, 0, 1, 0, 4, 0);
      add(8'h00, 0, 1, 0, 4, 0);
      // re-press of pending button 3 while full
      add(8'h08, 0, 1, 0, 4, 0);
      add(8'h08, 0, 1, 0, 4, 1);
      add(8'h00, 0, 1, 0, 4, 0);
      // drain: 0,1,2,3,3,4,5
      add(8'h00, 1, 1, 1, 4, 0);
      add(8'h00, 1, 1, 2, 4, 0);
      add(8'h00, 1, 1, 3, 4, 0);
      add(8'h00, 1, 1, 3, 3, 0);
      add(8'h00, 1, 1, 4, 2, 0);
      add(8'h00, 1, 1, 5, 1, 0);
      add(8'h00, 1, 0, 0, 0, 0);
      // re-press on the push edge
      add(8'h02, 0, 0, 0, 0, 0);
      add(8'h02, 0, 1, 1, 1, 0);
      add(8'h00, 0, 1, 1, 2, 0);
      add(8'h00, 1, 1, 1, 1, 0);
      add(8'h00, 1, 0, 0, 0, 0);
      // ready held high, back-to-back
      add(8'h06, 1, 0, 0, 0, 0);
      add(8'h00, 1, 1, 1, 1, 0);
      add(8'h00, 1, 1, 2, 1, 0);
      add(8'h00, 1, 0, 0, 0, 0);
      add(8'h00, 1, 0, 0, 0, 0);

      repeat (3) @(posedge clk5);
      #1;
      chk("reset valid", int'(bus.key_valid), 0);
      chk("reset count", int'(bus.count), 0);
      chk("reset ovf", int'(bus.overflow), 0);
      chk("reset code", int'(bus.key_code), 0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         press = vecs[i].press;
         bus.key_ready = vecs[i].ready;
         tick();
         chk($sformatf("v%0d valid", i), int'(bus.key_valid),
             int'(vecs[i].valid));
         chk($sformatf("v%0d count", i), int'(bus.count),
             int'(vecs[i].count));
         chk($sformatf("v%0d ovf", i), int'(bus.overflow),
             int'(vecs[i].ovf));
         if (vecs[i].valid)
            chk($sformatf("v%0d code", i), int'(bus.key_code),
                int'(vecs[i].code));
      end

      // async reset with count=3 and button 3 still pending
      press = 8'h0F;
      bus.key_ready = 1'b0;
      tick();
      press = '0;
      repeat (3) tick();
      chk("pre-rst count", int'(bus.count), 3);
      #2;
      reset = 1'b0;
      #1;
      chk("async valid", int'(bus.key_valid), 0);
      chk("async count", int'(bus.count), 0);
      chk("async ovf", int'(bus.overflow), 0);
      chk("async code", int'(bus.key_code), 0);
      tick();
      reset = 1'b1;
      bus.key_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post-rst valid %0d", i), int'(bus.key_valid), 0);
         chk($sformatf("post-rst count %0d", i), int'(bus.count), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
